// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the 8-way round-robin arbiter.
//   req         : requester -> arbiter, bit i = requester i
//   grant       : arbiter -> requesters, registered one-hot grant (or all zero)
//   grant_valid : arbiter -> requesters, registered, high when grant is non-zero
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic       grant_valid;

  modport master (output req, input grant, input grant_valid);
  modport slave  (input req, output grant, output grant_valid);
endinterface

// File: rtl/rr_arbiter8.sv
// Registered 8-way round-robin arbiter. Converts a raw request vector into a
// clean one-hot grant (or all zero) suitable for a strictly one-hot encoder.
// An owner keeps the grant while requesting, for at most HOLD_MAX consecutive
// cycles (0 = unlimited), after which arbitration is forced to rotate.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of rr_arbiter8_if (req in, grant / grant_valid out)
module rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter8_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Last hold_cnt value at which the owner may still keep the grant.
  localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] owner;
  logic [7:0] hold_cnt;
  logic [7:0] grant_q;
  logic       grant_valid_q;

  logic       found;
  logic [2:0] winner;
  logic       keep;

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;

  // Circular priority search starting at ptr. While in GRANT, ptr already
  // equals owner+1, so this same search serves re-arbitration.
  always_comb begin
    logic [2:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    keep = (state == GRANT) && bus.req[owner] &&
           ((HOLD_MAX == 0) || (hold_cnt < HOLD_LAST));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      hold_cnt      <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
    end else if (keep) begin
      // Saturate so unlimited hold never wraps the counter.
      if (hold_cnt != 8'hFF) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end else if (found) begin
      state         <= GRANT;
      grant_q       <= 8'd1 << winner;
      grant_valid_q <= 1'b1;
      owner         <= winner;
      ptr           <= winner + 3'd1;
      hold_cnt      <= '0;
    end else begin
      state         <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
    end
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Registered 8-way round-robin arbiter; turns a raw request vector into a clean one-hot grant.
- The grant feeds the downstream 8-to-3 encoder directly. That encoder requires strictly one-hot input, so this block guarantees one-hot or all-zero output every cycle.
- Grants are held while the owner keeps requesting, up to a configurable limit, then forcibly rotated for fairness.

Parameters:
- HOLD_MAX, 4, max consecutive cycles one requester may hold the grant; 0 = unlimited; legal range 0..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req  input  8  request vector; bit i = requester i; any number of bits may be set
- grant  output  8  registered grant; one-hot when grant_valid=1, else 8'b0
- grant_valid  output  1  registered; 1 when grant is non-zero

Behaviour:
- Reset (synchronous, active-high; sampled at rising edge of clk), next edge after rst=1:
  - grant=8'b0, grant_valid=0
  - state=IDLE, ptr=3'd0, hold_cnt=8'd0
  - rst has priority over all other inputs, including mid-grant; the grant drops at the first edge with rst=1.
- Internal state:
  - ptr: 3-bit, the highest-priority index for the next arbitration.
  - hold_cnt: 8-bit count of cycles the current owner has held the grant.
  - owner: index of the current grant bit.
- Arbitration function:
  - Search req circularly starting at ptr: ptr, ptr+1, ..., 7, 0, ..., ptr-1, using mod-8 wrap.
  - The first set bit wins.
  - On every new grant (including a re-grant to the same owner): ptr <= winner+1 mod 8 and hold_cnt <= 0.
- State IDLE (grant=0):
  - req==0: stay IDLE.
  - req!=0: go to GRANT; grant <= one-hot(winner), grant_valid <= 1.
  - Latency: req asserted at edge t gives grant visible after edge t+1, i.e. one register stage.
- State GRANT:
  - Owner still requesting and (HOLD_MAX==0 or hold_cnt < HOLD_MAX-1): keep grant, hold_cnt <= hold_cnt+1.
  - Owner drops req, or hold_cnt == HOLD_MAX-1 with HOLD_MAX != 0: re-arbitrate this cycle using the updated-rule ptr (= owner+1).
    - Another requester wins: new grant on the next edge, no idle bubble.
    - Only the owner still requests: owner is re-granted; hold_cnt restarts at 0.
    - req==0: go to IDLE; grant <= 0, grant_valid <= 0.
- Under unlimited hold (HOLD_MAX=0), hold_cnt saturates at 255 and never wraps.
- Invariants, every cycle:
  - $countones(grant) <= 1.
  - grant_valid == |grant.
  - A bit of grant is never set unless the matching req bit was set on the previous edge.
- ptr wraps from 7 to 0 naturally in 3-bit arithmetic.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> grant=0, grant_valid=0 throughout; state stays IDLE.
- After reset, req=8'b0000_0100 held, HOLD_MAX=4 -> grant=8'b0000_0100 from cycle 1. At the hold limit it is re-granted to the same owner (sole requester): grant stays 8'b0000_0100 continuously, no gap, and ptr=3.
- req=8'hFF held, HOLD_MAX=4 -> grant rotates 01,02,04,...,80,01, each held exactly 4 cycles; back-to-back handoff with no zero cycle; wrap from 8'h80 to 8'h01 checked.
- Owner 5 drops req while req=8'b0000_0011 -> next edge grant=8'b0000_0001 (search from ptr=6 wraps to 0). Then with all req dropped -> grant=0, grant_valid=0 one edge later.
- rst=1 asserted while grant=8'b0001_0000 mid-hold -> next edge grant=0, ptr=0. With req=8'hFF after release -> grant=8'h01.
- HOLD_MAX=0, req=8'b1000_0001 held 300 cycles -> requester 0 holds the whole time; no rotation; no hold_cnt wrap side effects. One-hot assertion checked on every cycle of every test.
